rggen_avalon_agent_bridge: RTL and testbench



---
 rtl/rggen_rtl_pkg.sv | 17 +
 rtl/rggen_bus_if.sv | 26 ++
 rtl/rggen_avalon_agent_bridge.sv | 139 +++++++++++++
 tb/tb_rggen_avalon_agent_bridge.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rggen_rtl_pkg.sv
// Shared rggen bus types: access kind and completion status.
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_POSTED_WRITE = 2'b01,
    RGGEN_READ         = 2'b10,
    RGGEN_WRITE        = 2'b11
  } rggen_access;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

endpackage

// File: rtl/rggen_bus_if.sv
// rggen register bus: one command per valid/ready handshake, response returned with ready.
interface rggen_bus_if
  import rggen_rtl_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned BUS_WIDTH     = 32
);
  logic                     valid;
  rggen_access              access;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [BUS_WIDTH-1:0]     write_data;
  logic [BUS_WIDTH/8-1:0]   strobe;
  logic                     ready;
  rggen_status              status;
  logic [BUS_WIDTH-1:0]     read_data;

  modport master (
    output valid, access, address, write_data, strobe,
    input  ready, status, read_data
  );

  modport slave (
    input  valid, access, address, write_data, strobe,
    output ready, status, read_data
  );
endinterface

// File: rtl/rggen_avalon_agent_bridge.sv
// Avalon-MM agent front end: accepts one host command at a time and replays it on the
// rggen register bus, returning a pipelined read or write response.
module rggen_avalon_agent_bridge
  import rggen_rtl_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned BUS_WIDTH     = 32,
  parameter bit          READ_STROBE   = 1'b1
)(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_read,
  input  logic                     i_write,
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  input  logic [BUS_WIDTH/8-1:0]   i_byteenable,
  input  logic [BUS_WIDTH-1:0]     i_writedata,
  output logic                     o_waitrequest,
  output logic                     o_readdatavalid,
  output logic                     o_writeresponsevalid,
  output logic [1:0]               o_response,
  output logic [BUS_WIDTH-1:0]     o_readdata,
  rggen_bus_if.master              bus_if
);

  localparam int unsigned STROBE_WIDTH      = BUS_WIDTH / 8;
  localparam int unsigned BUS_ADDRESS_WIDTH = $bits(bus_if.address);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY    = 2'b01,
    RESPOND = 2'b10
  } state_e;

  state_e                   state_q, state_d;
  rggen_access              access_q, access_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic [BUS_WIDTH-1:0]     write_data_q, write_data_d;
  logic [STROBE_WIDTH-1:0]  strobe_q, strobe_d;
  logic                     valid_q, valid_d;
  logic                     read_valid_q, read_valid_d;
  logic                     write_valid_q, write_valid_d;
  rggen_status              response_q, response_d;
  logic [BUS_WIDTH-1:0]     read_data_q, read_data_d;
  logic                     accept;

  // Reset forces waitrequest so nothing can be accepted while the block is held.
  assign o_waitrequest = (state_q == BUSY) || i_rst;
  assign accept        = (i_read || i_write) && !o_waitrequest;

  always_comb begin
    state_d       = state_q;
    access_d      = access_q;
    address_d     = address_q;
    write_data_d  = write_data_q;
    strobe_d      = strobe_q;
    valid_d       = valid_q;
    read_valid_d  = 1'b0;
    write_valid_d = 1'b0;
    response_d    = response_q;
    read_data_d   = read_data_q;

    unique case (state_q)
      IDLE, RESPOND: begin
        // A new command may be taken in the response cycle, giving back-to-back service.
        if (accept) begin
          access_d     = i_write ? RGGEN_WRITE : RGGEN_READ;
          address_d    = i_address;
          write_data_d = i_writedata;
          strobe_d     = (i_write || READ_STROBE) ? i_byteenable : '1;
          valid_d      = 1'b1;
          state_d      = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (bus_if.ready) begin
          valid_d       = 1'b0;
          response_d    = bus_if.status;
          read_valid_d  = (access_q == RGGEN_READ);
          write_valid_d = (access_q != RGGEN_READ);
          if (access_q == RGGEN_READ) begin
            read_data_d = bus_if.read_data;
          end
          state_d = RESPOND;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= IDLE;
      access_q      <= rggen_access'(2'b00);
      address_q     <= '0;
      write_data_q  <= '0;
      strobe_q      <= '0;
      valid_q       <= 1'b0;
      read_valid_q  <= 1'b0;
      write_valid_q <= 1'b0;
      response_q    <= RGGEN_OKAY;
      read_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      access_q      <= access_d;
      address_q     <= address_d;
      write_data_q  <= write_data_d;
      strobe_q      <= strobe_d;
      valid_q       <= valid_d;
      read_valid_q  <= read_valid_d;
      write_valid_q <= write_valid_d;
      response_q    <= response_d;
      read_data_q   <= read_data_d;
    end
  end

  assign bus_if.valid      = valid_q;
  assign bus_if.access     = access_q;
  assign bus_if.address    = BUS_ADDRESS_WIDTH'(address_q);
  assign bus_if.write_data = write_data_q;
  assign bus_if.strobe     = strobe_q;

  assign o_readdatavalid      = read_valid_q;
  assign o_writeresponsevalid = write_valid_q;
  assign o_response           = response_q;
  assign o_readdata           = read_data_q;

`ifndef SYNTHESIS
  // Simultaneous read and write is a host protocol violation; the write is serviced.
  read_write_exclusive: assert property (
    @(posedge i_clk) disable iff (i_rst) !(i_read && i_write)
  );
`endif

endmodule

// File: tb/tb_rggen_avalon_agent_bridge.sv
// Scoreboard bench: directed Avalon commands, a programmable rggen responder and
// monitors that check bus commands and host responses against queued expectations.
module tb_rggen_avalon_agent_bridge;
  import rggen_rtl_pkg::*;

  localparam int unsigned AW = 16;
  localparam int unsigned BW = 32;
  localparam int unsigned SW = BW / 8;

  typedef struct {
    int          delay;
    rggen_status status;
    logic [31:0] rdata;
  } cfg_t;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  stb1;
    logic [3:0]  stb0;
  } cmd_t;

  typedef struct {
    logic        wr;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, i_write;
  logic [AW-1:0] i_address;
  logic [SW-1:0] i_byteenable;
  logic [BW-1:0] i_writedata;

  logic          wait1, rdv1, wrv1;
  logic [1:0]    resp1;
  logic [BW-1:0] rdata1;
  logic          wait0, rdv0, wrv0;
  logic [1:0]    resp0;
  logic [BW-1:0] rdata0;

  rggen_bus_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) bus1 ();
  rggen_bus_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) bus0 ();

  rggen_avalon_agent_bridge #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .READ_STROBE(1'b1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_read(i_read), .i_write(i_write), .i_address(i_address),
    .i_byteenable(i_byteenable), .i_writedata(i_writedata), .o_waitrequest(wait1),
    .o_readdatavalid(rdv1), .o_writeresponsevalid(wrv1), .o_response(resp1),
    .o_readdata(rdata1), .bus_if(bus1)
  );

  rggen_avalon_agent_bridge #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .READ_STROBE(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_read(i_read), .i_write(i_write), .i_address(i_address),
    .i_byteenable(i_byteenable), .i_writedata(i_writedata), .o_waitrequest(wait0),
    .o_readdatavalid(rdv0), .o_writeresponsevalid(wrv0), .o_response(resp0),
    .o_readdata(rdata0), .bus_if(bus0)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   vcnt = 0;
  int   wcnt = 0;
  int   rise_cyc = 0;
  int   last_resp_cyc = 0;
  int   resp_total = 0;
  int   rvalid_total = 0;
  int   wvalid_total = 0;
  int   acc_cyc = 0;
  logic valid_prev = 1'b0;

  cfg_t cfg_q[$];
  cmd_t cmd_q[$];
  rsp_t rsp_q[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // rggen responder: both bus copies see identical ready/status/read_data.
  initial begin
    int cnt;
    cnt = 0;
    bus1.ready = 1'b0; bus1.status = RGGEN_OKAY; bus1.read_data = '0;
    bus0.ready = 1'b0; bus0.status = RGGEN_OKAY; bus0.read_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus1.valid && cfg_q.size() > 0) begin
        if (cnt == cfg_q[0].delay) begin
          bus1.ready = 1'b1; bus1.status = cfg_q[0].status; bus1.read_data = cfg_q[0].rdata;
          bus0.ready = 1'b1; bus0.status = cfg_q[0].status; bus0.read_data = cfg_q[0].rdata;
          void'(cfg_q.pop_front());
          cnt = 0;
        end else begin
          bus1.ready = 1'b0;
          bus0.ready = 1'b0;
          cnt++;
        end
      end else begin
        bus1.ready = 1'b0;
        bus0.ready = 1'b0;
        cnt = 0;
      end
    end
  end

  // Monitors: bus command handshakes and host response strobes.
  always @(negedge clk) begin
    if (bus1.valid) vcnt++;
    if (wait1) wcnt++;
    if (bus1.valid && !valid_prev) rise_cyc = cyc;
    valid_prev = bus1.valid;

    if (bus1.valid && bus1.ready) begin
      if (cmd_q.size() == 0) begin
        check("unexpected_bus_cmd", 32'(bus1.address), 32'hFFFF_FFFF);
      end else begin
        cmd_t c;
        c = cmd_q.pop_front();
        check("bus_access", 32'(bus1.access), 32'(c.wr ? RGGEN_WRITE : RGGEN_READ));
        check("bus_address", 32'(bus1.address), 32'(c.addr));
        if (c.wr) check("bus_write_data", bus1.write_data, c.wdata);
        check("bus_strobe_rs1", 32'(bus1.strobe), 32'(c.stb1));
        check("bus_strobe_rs0", 32'(bus0.strobe), 32'(c.stb0));
        check("bus_valid_rs0", 32'(bus0.valid), 32'd1);
      end
    end

    if (rdv1 || wrv1) begin
      resp_total++;
      last_resp_cyc = cyc;
      if (rdv1) rvalid_total++;
      if (wrv1) wvalid_total++;
      if (rsp_q.size() == 0) begin
        check("unexpected_response", 32'({rdv1, wrv1}), 32'd0);
      end else begin
        rsp_t r;
        r = rsp_q.pop_front();
        check("rsp_strobes", 32'({rdv1, wrv1}), r.wr ? 32'd1 : 32'd2);
        check("rsp_code", 32'(resp1), 32'(r.resp));
        check("rsp_strobes_rs0", 32'({rdv0, wrv0}), r.wr ? 32'd1 : 32'd2);
        check("rsp_code_rs0", 32'(resp0), 32'(r.resp));
        if (!r.wr) begin
          check("rsp_readdata", rdata1, r.rdata);
          check("rsp_readdata_rs0", rdata0, r.rdata);
        end
      end
    end
  end

  task automatic send(input logic wr, input logic [15:0] addr, input logic [3:0] be,
                      input logic [31:0] wdata, input int delay, input rggen_status st,
                      input logic [31:0] rdata, input bit track, input bit hold);
    int n;
    i_write = wr; i_read = !wr; i_address = addr; i_byteenable = be; i_writedata = wdata;
    if (track) begin
      cfg_q.push_back('{delay, st, rdata});
      cmd_q.push_back('{wr, addr, wdata, be, wr ? be : 4'hF});
      rsp_q.push_back('{wr, 2'(st), rdata});
    end
    n = 0;
    while (wait1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 40) begin
      check("accept_timeout", 32'(wait1), 32'd0);
      i_read = 1'b0; i_write = 1'b0;
      return;
    end
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    if (!hold) begin
      i_read = 1'b0; i_write = 1'b0;
    end
  endtask

  task automatic wait_resp(input int target);
    int n;
    n = 0;
    while (resp_total < target && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (resp_total < target) check("response_timeout", 32'(resp_total), 32'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int base, vbase, wbase, rbase, wvbase, r_first;
    rst = 1'b1; i_read = 1'b0; i_write = 1'b0;
    i_address = '0; i_byteenable = '0; i_writedata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_waitrequest", 32'(wait1), 32'd1);
    check("rst_bus_valid", 32'(bus1.valid), 32'd0);
    check("rst_strobes", 32'({rdv1, wrv1}), 32'd0);
    check("rst_response", 32'(resp1), 32'd0);
    check("rst_readdata", rdata1, 32'd0);
    rst = 1'b0;
    #1;
    check("idle_waitrequest", 32'(wait1), 32'd0);
    @(posedge clk);
    #1;

    // Write, ready in first busy cycle
    base = resp_total; vbase = vcnt;
    check("wr_accept_waitrequest", 32'(wait1), 32'd0);
    send(1'b1, 16'h0010, 4'hF, 32'hDEAD_BEEF, 0, RGGEN_OKAY, 32'h0, 1'b1, 1'b0);
    wait_resp(base + 1);
    check("wr_latency", 32'(last_resp_cyc - acc_cyc), 32'd2);
    check("wr_valid_cycles", 32'(vcnt - vbase), 32'd1);
    @(posedge clk); #1;

    // Read with ready delayed three cycles
    base = resp_total; vbase = vcnt; wbase = wcnt; wvbase = wvalid_total;
    send(1'b0, 16'h0004, 4'hF, 32'h0, 3, RGGEN_OKAY, 32'h1234_5678, 1'b1, 1'b0);
    wait_resp(base + 1);
    check("rd_latency", 32'(last_resp_cyc - acc_cyc), 32'd5);
    check("rd_valid_cycles", 32'(vcnt - vbase), 32'd4);
    check("rd_wait_cycles", 32'(wcnt - wbase), 32'd4);
    check("rd_no_write_strobe", 32'(wvalid_total - wvbase), 32'd0);
    @(posedge clk); #1;

    // Error responses; read data holds across a write
    base = resp_total;
    send(1'b1, 16'h0100, 4'hF, 32'h5555_AAAA, 1, RGGEN_SLAVE_ERROR, 32'h0, 1'b1, 1'b0);
    wait_resp(base + 1);
    check("readdata_hold_after_write", rdata1, 32'h1234_5678);
    @(posedge clk); #1;
    check("response_hold", 32'(resp1), 32'd2);
    base = resp_total;
    send(1'b0, 16'hFFFC, 4'hF, 32'h0, 0, RGGEN_DECODE_ERROR, 32'hA5A5_0001, 1'b1, 1'b0);
    wait_resp(base + 1);
    @(posedge clk); #1;

    // Back-to-back: second command presented right after the first is accepted
    base = resp_total;
    send(1'b1, 16'h0020, 4'h3, 32'h0BAD_F00D, 0, RGGEN_OKAY, 32'h0, 1'b1, 1'b1);
    send(1'b0, 16'h0008, 4'h3, 32'h0, 1, RGGEN_EXOKAY, 32'hCAFE_0001, 1'b1, 1'b0);
    r_first = last_resp_cyc;
    check("b2b_accept_in_respond", 32'(acc_cyc), 32'(r_first));
    wait_resp(base + 2);
    check("b2b_valid_rise", 32'(rise_cyc), 32'(r_first + 1));
    @(posedge clk); #1;

    // Reset during the second busy cycle of a read
    rbase = rvalid_total;
    send(1'b0, 16'h000C, 4'hF, 32'h0, 0, RGGEN_OKAY, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("abort_busy_valid", 32'(bus1.valid), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_valid_drop", 32'(bus1.valid), 32'd0);
    check("abort_waitrequest", 32'({wait1, wait0}), 32'd3);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_release_waitrequest", 32'(wait1), 32'd0);
    check("abort_readdata_reset", rdata1, 32'd0);
    check("abort_response_reset", 32'(resp1), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_readdatavalid", 32'(rvalid_total - rbase), 32'd0);
    base = resp_total;
    send(1'b1, 16'h0040, 4'h6, 32'h1357_9BDF, 1, RGGEN_OKAY, 32'h0, 1'b1, 1'b0);
    wait_resp(base + 1);
    repeat (3) @(posedge clk);
    #1;

    check("cmd_queue_drained", 32'(cmd_q.size()), 32'd0);
    check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    check("cfg_queue_drained", 32'(cfg_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
